tnn_neuron_accum: RTL and testbench
===================================

// Module: tnn_neuron_accum
// PURPOSE
//  Ternary-neuron accumulator stage directly downstream of the 22-input popcount units.
//  - Each beat carries two popcounts: positive-weight inputs and negative-weight inputs.
//  - Accumulates the signed difference (pos - neg) over a multi-beat neuron evaluation.
//  - On the last beat, compares the sum with two thresholds and emits a ternary
//    activation (-1/0/+1) over a valid/ready handshake.
// PARAMETERS
//  PC_W       5   popcount operand width (matches 5-bit popcount22 output, max value 22)
//  ACC_W      10  signed accumulator width, two's complement
//  MAX_BEATS  8   beat limit per neuron; reaching it forces end-of-neuron and flags error
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      beat valid
//  in_ready   out  1      beat accepted when in_valid & in_ready
//  in_last    in   1      final beat of the current neuron
//  pos_pc     in   PC_W   popcount of +1-weighted inputs (unsigned)
//  neg_pc     in   PC_W   popcount of -1-weighted inputs (unsigned)
//  thr_hi     in   ACC_W  signed upper threshold, sampled on the accepted last beat
//  thr_lo     in   ACC_W  signed lower threshold, sampled on the accepted last beat
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_act    out  2      ternary activation: 2'b01=+1, 2'b00=0, 2'b11=-1
//  out_sum    out  ACC_W  final signed sum
//  out_err    out  1      set if MAX_BEATS was reached without in_last (or overflow, see CONFIGURATION)
// BEHAVIOUR
//  - Single clock domain. Synchronous active-high reset.
//  - Reset values: state=ACC, acc=0, beat_cnt=0, in_ready=1, out_valid=0, out_act=0,
//    out_sum=0, out_err=0. Reset mid-neuron discards the partial sum. Reset with
//    out_valid high drops the pending result.
//  - FSM has two states:
//    ACC: in_ready=1. On each accepted beat, acc <= acc + zext(pos_pc) - zext(neg_pc)
//      and beat_cnt++.
//      End of neuron occurs when the accepted beat has in_last=1, or when beat_cnt
//      == MAX_BEATS-1 (forced end, err=1). Then:
//        - sum = acc + pos - neg
//        - out_act = (sum > thr_hi) ? +1 : (sum < thr_lo) ? -1 : 0
//        - out_sum = sum
//        - out_valid <= 1 on the next cycle (latency 1 from the last beat)
//        - go to OUT
//    OUT: in_ready=0. out_act, out_sum and out_err are stable. On out_ready:
//      out_valid <= 0, acc <= 0, beat_cnt <= 0, out_err <= 0, go to ACC.
//      Input is accepted again from the following cycle (no same-cycle bypass).
//  - Compare rules:
//    - Compares are signed.
//    - If thr_lo > thr_hi: sum > thr_hi gives +1 (priority), else sum < thr_lo gives -1.
//  - Single-beat neuron (first beat has in_last=1) is legal: result is pos - neg.
//  - in_valid=0 stalls the accumulation and leaves state unchanged.
// CONFIGURATION
//  TNN_SAT_EN defined:
//    - acc and sum saturate at [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    - Any clamp during the neuron sets out_err.
//  TNN_SAT_EN undefined:
//    - acc and sum wrap modulo 2^ACC_W.
//    - out_err reflects only the beat-limit condition.
// STRUCTURE
//  - Package tnn_pkg holds:
//    - act_t, a 2-bit ternary encoding with constants ACT_POS / ACT_ZERO / ACT_NEG
//    - state_t enum {ACC, OUT}
//    - function sat_add() used under TNN_SAT_EN
//  - Sub-module tnn_ternary_thresh: combinational (sum, thr_hi, thr_lo) -> act.
//    It is reused by the bias/pooling stages.
// TESTING
//  1. Reset, then 3 beats (pos,neg)=(10,2),(5,7),(22,0) with last on beat 3, thr_hi=20,
//     thr_lo=-5 -> out_sum=28, out_act=01, out_err=0, out_valid 1 cycle after beat 3.
//  2. Single beat (0,22), last, thr_lo=-10 -> out_sum=-22, out_act=11.
//  3. sum == thr_hi == 4 -> out_act=00. sum == thr_lo == -4 -> out_act=00.
//  4. Hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable, no beats accepted.
//     Release -> in_ready=1 on the next cycle, and the next neuron starts from acc=0.
//  5. MAX_BEATS=8 beats of (1,0) with no in_last -> forced end, out_sum=8, out_err=1.
//  6. ACC_W=6 with 3 beats of (22,0): TNN_SAT_EN gives out_sum=31, out_err=1;
//     without it out_sum=2 (66 mod 64). Also assert rst mid-neuron -> next result
//     excludes the pre-reset beats.

Source files
------------

// File: rtl/tnn_neuron_accum_pkg.sv
// Shared types for the ternary-neuron datapath: activation encoding, accumulator FSM states,
// and the saturating adder used when TNN_SAT_EN is defined.
package tnn_pkg;

  typedef logic [1:0] act_t;
  localparam act_t ACT_POS  = 2'b01;
  localparam act_t ACT_ZERO = 2'b00;
  localparam act_t ACT_NEG  = 2'b11;

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  // Returns {clamped, value}; value is clamped to the signed range of a w-bit word.
  function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input int w);
    logic signed [31:0] r, mx, mn;
    r  = a + b;
    mx = (32'sd1 <<< (w - 1)) - 32'sd1;
    mn = -(32'sd1 <<< (w - 1));
    if (r > mx) return {1'b1, mx};
    if (r < mn) return {1'b1, mn};
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/tnn_neuron_accum_if.sv
// Beat-in / result-out handshake bundle for the ternary-neuron accumulator.
interface tnn_neuron_accum_if #(
  parameter int PC_W  = 5,
  parameter int ACC_W = 10
);
  import tnn_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [PC_W-1:0]         pos_pc;
  logic [PC_W-1:0]         neg_pc;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  act_t                    out_act;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_err;

  modport master (
    output in_valid, in_last, pos_pc, neg_pc, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_last, pos_pc, neg_pc, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_err
  );
endinterface

// File: rtl/tnn_neuron_accum_thresh.sv
// Signed two-threshold ternary quantiser; the upper threshold wins when the thresholds cross.
module tnn_ternary_thresh
  import tnn_pkg::*;
#(
  parameter int W = 10
) (
  input  logic signed [W-1:0] sum_i,
  input  logic signed [W-1:0] thr_hi_i,
  input  logic signed [W-1:0] thr_lo_i,
  output act_t                act_o
);

  always_comb begin
    act_o = ACT_ZERO;
    if (sum_i > thr_hi_i)      act_o = ACT_POS;
    else if (sum_i < thr_lo_i) act_o = ACT_NEG;
  end

endmodule

// File: rtl/tnn_neuron_accum.sv
// Ternary-neuron accumulator: sums (pos - neg) popcounts per beat, thresholds on the last beat.
// Define TNN_SAT_EN for saturating arithmetic (clamps flag out_err); default wraps.
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 8
) (
  input logic               clk,
  input logic               rst,
  tnn_neuron_accum_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q, out_sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_ready_q, out_valid_q, out_err_q;
  act_t                    out_act_q, act_d;
  logic                    accept, limit, done, err_d;

  assign accept = bus.in_valid & in_ready_q;
  assign limit  = (cnt_q == CNT_W'(MAX_BEATS - 1));
  assign done   = bus.in_last | limit;

`ifdef TNN_SAT_EN
  logic                clamp_q, clamp_d;
  logic [32:0]         sat_r;
  logic signed [31:0]  delta;

  always_comb begin
    delta   = 32'(bus.pos_pc) - 32'(bus.neg_pc);
    sat_r   = sat_add(32'(acc_q), delta, ACC_W);
    sum_d   = sat_r[ACC_W-1:0];
    clamp_d = sat_r[32];
  end

  // Clamps on earlier beats are remembered until the neuron's result is emitted.
  assign err_d = (limit & ~bus.in_last) | clamp_q | clamp_d;

  always_ff @(posedge clk) begin
    if (rst)                        clamp_q <= 1'b0;
    else if (accept && !done)       clamp_q <= clamp_q | clamp_d;
    else if (state_q == OUT && bus.out_ready) clamp_q <= 1'b0;
  end
`else
  always_comb begin
    sum_d = acc_q + ACC_W'(bus.pos_pc) - ACC_W'(bus.neg_pc);
  end

  assign err_d = limit & ~bus.in_last;
`endif

  tnn_ternary_thresh #(.W(ACC_W)) u_thresh (
    .sum_i    (sum_d),
    .thr_hi_i (bus.thr_hi),
    .thr_lo_i (bus.thr_lo),
    .act_o    (act_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_act_q   <= ACT_ZERO;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
              out_sum_q   <= sum_d;
              out_act_q   <= act_d;
              out_err_q   <= err_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= OUT;
            end
          end
        end
        OUT: begin
          // Input re-opens only on the cycle after the result is consumed.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Directed-vector bench for tnn_neuron_accum; a second ACC_W=6 instance covers overflow/saturation.
module tb_tnn_neuron_accum;
  import tnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_neuron_accum_if #(.PC_W(5), .ACC_W(10)) bus ();
  tnn_neuron_accum_if #(.PC_W(5), .ACC_W(6))  bus6 ();

  tnn_neuron_accum #(.PC_W(5), .ACC_W(10), .MAX_BEATS(8)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  tnn_neuron_accum #(.PC_W(5), .ACC_W(6), .MAX_BEATS(8)) u_dut6 (
    .clk (clk), .rst (rst), .bus (bus6)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input int n, input logic last, input int hi, input int lo);
    bus.in_valid = 1'b1;
    bus.pos_pc   = 5'(p);
    bus.neg_pc   = 5'(n);
    bus.in_last  = last;
    bus.thr_hi   = 10'(hi);
    bus.thr_lo   = 10'(lo);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic beat6(input int p, input int n, input logic last);
    bus6.in_valid = 1'b1;
    bus6.pos_pc   = 5'(p);
    bus6.neg_pc   = 5'(n);
    bus6.in_last  = last;
    bus6.thr_hi   = 6'(31);
    bus6.thr_lo   = 6'(-32);
    tick();
    bus6.in_valid = 1'b0;
    bus6.in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input int s, input logic [1:0] a, input logic e);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   bus.out_sum, s);
    chk({tag, "_act"},   32'(bus.out_act), 32'(a));
    chk({tag, "_err"},   32'(bus.out_err), 32'(e));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0; bus.in_last  = 1'b0; bus.pos_pc  = '0; bus.neg_pc  = '0;
    bus.thr_hi    = '0;   bus.thr_lo   = '0;   bus.out_ready  = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_last = 1'b0; bus6.pos_pc = '0; bus6.neg_pc = '0;
    bus6.thr_hi   = '0;   bus6.thr_lo  = '0;   bus6.out_ready = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_act",   32'(bus.out_act), 32'd0);
    chk("rst_out_sum",   bus.out_sum, 32'd0);
    chk("rst_out_err",   32'(bus.out_err), 32'd0);

    // three-beat neuron: 8 - 2 + 22 = 28 > 20
    beat(10, 2, 1'b0, 20, -5);
    beat(5, 7, 1'b0, 20, -5);
    chk("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    beat(22, 0, 1'b1, 20, -5);
    chk("t1_in_ready_low", 32'(bus.in_ready), 32'd0);
    collect("t1", 28, 2'b01, 1'b0);

    beat(0, 22, 1'b1, 20, -10);
    collect("t2", -22, 2'b11, 1'b0);

    // equality with either threshold stays zero
    beat(6, 2, 1'b1, 4, -4);
    collect("t3_eq_hi", 4, 2'b00, 1'b0);
    beat(2, 6, 1'b1, 4, -4);
    collect("t3_eq_lo", -4, 2'b00, 1'b0);
    // crossed thresholds: upper compare takes priority
    beat(6, 2, 1'b1, 0, 10);
    collect("t3_cross_pos", 4, 2'b01, 1'b0);
    beat(2, 6, 1'b1, 0, 10);
    collect("t3_cross_neg", -4, 2'b11, 1'b0);

    // backpressure: offered beats must be ignored while the result is held
    beat(3, 1, 1'b1, 10, -10);
    bus.in_valid = 1'b1; bus.pos_pc = 5'd9; bus.neg_pc = 5'd0; bus.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_ready", 32'(bus.in_ready), 32'd0);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_sum",   bus.out_sum, 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("t4_release_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_release_ready", 32'(bus.in_ready), 32'd1);
    beat(1, 0, 1'b1, 0, -1);
    collect("t4_next", 1, 2'b01, 1'b0);

    // beat limit: eighth beat forces the end and flags error
    for (int i = 0; i < 7; i++) beat(1, 0, 1'b0, 100, -100);
    chk("t5_not_yet", 32'(bus.out_valid), 32'd0);
    beat(1, 0, 1'b0, 100, -100);
    collect("t5", 8, 2'b00, 1'b1);

    // narrow accumulator, with a reset dropping two earlier beats
    beat6(22, 0, 1'b0);
    beat6(22, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ready", 32'(bus6.in_ready), 32'd1);
    beat6(22, 0, 1'b0);
    beat6(22, 0, 1'b0);
    beat6(22, 0, 1'b1);
    chk("t6_valid", 32'(bus6.out_valid), 32'd1);
    chk("t6_act",   32'(bus6.out_act), 32'd0);
`ifdef TNN_SAT_EN
    chk("t6_sum", bus6.out_sum, 32'd31);
    chk("t6_err", 32'(bus6.out_err), 32'd1);
`else
    chk("t6_sum", bus6.out_sum, 32'd2);
    chk("t6_err", 32'(bus6.out_err), 32'd0);
`endif
    bus6.out_ready = 1'b1;
    tick();
    bus6.out_ready = 1'b0;
    chk("t6_drop", 32'(bus6.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
